// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer
// Brief    : Splits one vlw/vsw vector access into LANES single-word memory
//            accesses and steers load data into vector register lanes.
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       is_store,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [LANES*DATA_W-1:0]    st_data,
    output logic                       stall,
    output logic                       done,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       vreg_we,
    output logic [$clog2(LANES)-1:0]   vreg_lane,
    output logic [DATA_W-1:0]          vreg_wdata
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] c_ONE_LANE  = LANE_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [LANE_W-1:0]       r_lane;
    logic [LANE_W-1:0]       w_next_lane;
    logic                    r_is_store;
    logic [ADDR_W-1:0]       r_addr;
    logic [LANES*DATA_W-1:0] r_st_data;
    logic                    w_latch;
    logic [ADDR_W-1:0]       w_lane_addr;
    logic [DATA_W-1:0]       w_st_lanes [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_st_lanes
            assign w_st_lanes[gi] = r_st_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Lane offset is a word index; the sum wraps modulo 2^ADDR_W.
    assign w_lane_addr = r_addr + {{(ADDR_W-LANE_W-2){1'b0}}, r_lane, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lane     <= '0;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_st_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_lane  <= w_next_lane;
            if (w_latch) begin
                r_is_store <= is_store;
                r_addr     <= {base_addr[ADDR_W-1:2], 2'b00};
                r_st_data  <= st_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_lane  = r_lane;
        w_latch      = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        vreg_we      = 1'b0;
        vreg_lane    = '0;
        vreg_wdata   = '0;
        case (r_state)
            IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                stall = start & ~rst;
                if (start) begin
                    w_latch      = 1'b1;
                    w_next_lane  = '0;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = r_is_store;
                mem_addr = w_lane_addr;
                if (r_is_store) begin
                    mem_wdata = w_st_lanes[r_lane];
                end
                if (mem_gnt) begin
                    if (!r_is_store) begin
                        w_next_state = WAIT;
                    end else if (r_lane == c_LAST_LANE) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_lane = r_lane + c_ONE_LANE;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    vreg_we    = 1'b1;
                    vreg_lane  = r_lane;
                    vreg_wdata = mem_rdata;
                    if (r_lane == c_LAST_LANE) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_lane  = r_lane + c_ONE_LANE;
                        w_next_state = REQ;
                    end
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Brief    : Directed self-checking bench for vec_mem_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [31:0]  base_addr;
    logic [127:0] st_data;
    logic         stall, done, mem_req, mem_we, mem_gnt, mem_rvalid, vreg_we;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata, vreg_wdata;
    logic [1:0]   vreg_lane;

    vec_mem_sequencer #(.ADDR_W(32), .DATA_W(32), .LANES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .st_data(st_data), .stall(stall), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .vreg_we(vreg_we), .vreg_lane(vreg_lane),
        .vreg_wdata(vreg_wdata)
    );

    always #5 clk = ~clk;

    // Memory model: grant unless a hold is pending on hold_addr; load data
    // returns one cycle after grant as address ^ 0xFFFF.
    int          cyc = 0;
    int          hold_used = 0;
    int          hold_req = 0;
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    logic        nxt_pend = 1'b0, r_pend = 1'b0, nxt_hold = 1'b0;
    logic [31:0] nxt_paddr = '0, r_paddr = '0;
    logic        rv_mask = 1'b0, rv_force = 1'b0;

    assign mem_gnt    = !(mem_addr == hold_addr && hold_used < hold_req);
    assign mem_rvalid = (r_pend & ~rv_mask) | rv_force;
    assign mem_rdata  = r_paddr ^ 32'h0000_FFFF;

    logic [31:0] wr_addr[$], wr_data[$], rd_addr[$], held_addr[$], held_data[$], vw_data[$];
    int          wr_cyc[$], vw_lane[$];

    always @(negedge clk) begin
        nxt_pend  = mem_req & mem_gnt & ~mem_we;
        nxt_paddr = mem_addr;
        nxt_hold  = mem_req & ~mem_gnt;
        if (mem_req && mem_gnt && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (mem_req && mem_gnt && !mem_we) rd_addr.push_back(mem_addr);
        if (mem_req && !mem_gnt) begin
            held_addr.push_back(mem_addr);
            held_data.push_back(mem_wdata);
        end
        if (vreg_we) begin
            vw_lane.push_back(int'(vreg_lane));
            vw_data.push_back(vreg_wdata);
        end
    end

    always @(posedge clk) begin
        r_pend  <= nxt_pend;
        r_paddr <= nxt_paddr;
        if (nxt_hold) hold_used <= hold_used + 1;
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete();
        held_addr.delete(); held_data.delete(); vw_lane.delete(); vw_data.delete();
    endtask

    task automatic launch(input logic st, input logic [31:0] base, input logic [127:0] data);
        @(posedge clk); #1;
        start = 1'b1; is_store = st; base_addr = base; st_data = data;
    endtask

    // Returns cycles from the first sampled cycle to done (-1 on timeout).
    task automatic wait_done(input logic hold, output int lat, output int nst);
        lat = -1; nst = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall) nst++;
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
        end
        if (lat < 0) check_eq("done_timeout", 128'(0), 128'(1));
    endtask

    logic [31:0] exp_vw [4] = '{32'hFDFF, 32'hFDFB, 32'hFDF7, 32'hFDF3};
    logic [31:0] exp_a;
    int          lat, nst;

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; st_data = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs",
                 {stall, done, mem_req, mem_we, mem_addr, mem_wdata, vreg_we, vreg_lane, vreg_wdata}, '0);
        @(posedge clk); #1; rst = 1'b0;

        // vsw, grant always high
        clear_logs();
        launch(1'b1, 32'h100, {32'hD, 32'hC, 32'hB, 32'hA});
        wait_done(1'b0, lat, nst);
        check_eq("vsw_latency", 128'(lat), 128'(5));
        check_eq("vsw_stall_cycles", 128'(nst), 128'(5));
        check_eq("vsw_write_count", 128'(wr_addr.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h100 + 32'(4 * i);
            check_eq($sformatf("vsw_addr%0d", i), (i < wr_addr.size()) ? wr_addr[i] : 'x, exp_a);
            check_eq($sformatf("vsw_data%0d", i), (i < wr_data.size()) ? wr_data[i] : 'x, 32'(10 + i));
        end
        if (wr_cyc.size() == 4) check_eq("vsw_back_to_back", 128'(wr_cyc[3] - wr_cyc[0]), 128'(3));
        @(negedge clk);
        check_eq("idle_after_done", {stall, done, mem_req}, '0);

        // vlw, rvalid one cycle after grant
        clear_logs();
        launch(1'b0, 32'h200, '0);
        wait_done(1'b0, lat, nst);
        check_eq("vlw_latency", 128'(lat), 128'(9));
        check_eq("vlw_vreg_count", 128'(vw_lane.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("vlw_lane%0d", i), (i < vw_lane.size()) ? 128'(vw_lane[i]) : 'x, 128'(i));
            check_eq($sformatf("vlw_data%0d", i), (i < vw_data.size()) ? vw_data[i] : 'x, exp_vw[i]);
        end

        // vsw with grant withheld three cycles on lane 2
        clear_logs();
        hold_addr = 32'h108; hold_req = hold_used + 3;
        launch(1'b1, 32'h100, {32'hD, 32'hC, 32'hB, 32'hA});
        wait_done(1'b0, lat, nst);
        hold_addr = 32'hFFFF_FFFF;
        check_eq("hold_latency", 128'(lat), 128'(8));
        check_eq("hold_write_count", 128'(wr_addr.size()), 128'(4));
        check_eq("hold_wait_cycles", 128'(held_addr.size()), 128'(3));
        for (int i = 0; i < held_addr.size(); i++) begin
            check_eq($sformatf("hold_addr%0d", i), held_addr[i], 32'h108);
            check_eq($sformatf("hold_data%0d", i), held_data[i], 32'hC);
        end

        // misaligned base is word-aligned
        clear_logs();
        launch(1'b0, 32'h103, '0);
        wait_done(1'b0, lat, nst);
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h100 + 32'(4 * i);
            check_eq($sformatf("misalign_addr%0d", i), (i < rd_addr.size()) ? rd_addr[i] : 'x, exp_a);
        end

        // address wraps past the top of memory
        clear_logs();
        launch(1'b0, 32'hFFFF_FFF8, '0);
        wait_done(1'b0, lat, nst);
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'hFFFF_FFF8 + 32'(4 * i);
            check_eq($sformatf("wrap_addr%0d", i), (i < rd_addr.size()) ? rd_addr[i] : 'x, exp_a);
        end

        // reset while waiting on lane 1 data
        clear_logs();
        launch(1'b0, 32'h300, '0);
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; rv_mask = 1'b1;
        @(posedge clk); #1;
        check_eq("pre_reset_stall", 128'(stall), 128'(1));
        rst = 1'b1;
        #1;
        check_eq("midseq_reset_outputs",
                 {stall, done, mem_req, mem_we, mem_addr, mem_wdata, vreg_we, vreg_lane, vreg_wdata}, '0);
        @(posedge clk); #1; rst = 1'b0; rv_mask = 1'b0; rv_force = 1'b1;
        repeat (2) @(posedge clk);
        #1; rv_force = 1'b0;
        check_eq("late_rvalid_vreg", 128'(vw_lane.size()), 128'(1));
        clear_logs();
        launch(1'b0, 32'h400, '0);
        wait_done(1'b0, lat, nst);
        check_eq("restart_latency", 128'(lat), 128'(9));
        check_eq("restart_first_lane", (vw_lane.size() > 0) ? 128'(vw_lane[0]) : 'x, 128'(0));
        check_eq("restart_first_addr", (rd_addr.size() > 0) ? rd_addr[0] : 'x, 32'h400);

        // start held high through a whole vsw and its DONE
        clear_logs();
        launch(1'b1, 32'h500, {32'h4, 32'h3, 32'h2, 32'h1});
        wait_done(1'b1, lat, nst);
        check_eq("held_start_latency", 128'(lat), 128'(5));
        check_eq("held_start_writes", 128'(wr_addr.size()), 128'(4));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("held_start_idle_stall", {stall, mem_req}, 2'b10);
        @(posedge clk); #1; start = 1'b0;
        wait_done(1'b0, lat, nst);
        check_eq("second_seq_latency", 128'(lat), 128'(4));
        check_eq("second_seq_writes", 128'(wr_addr.size()), 128'(8));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
